// File: rtl/aurora_pkg.sv
// Shared definitions for the Aurora TX arbiter: tag magics, FSM encoding and the
// stream beat payload.
package aurora_pkg;

  localparam int unsigned CH_W   = 3;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned KEEP_W = 4;

  localparam logic [15:0] HDR_MAGIC   = 16'hA5C3;
  localparam logic [15:0] ABORT_MAGIC = 16'hDEAD;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
  } beat_t;

  // Full-keep tag word carrying a magic, a count field and the channel index.
  function automatic beat_t tag_word(input logic [15:0] magic, input logic [7:0] cnt,
                                     input logic [CH_W-1:0] ch, input logic last);
    beat_t b;
    b.data = {magic, cnt, 8'(ch)};
    b.keep = 4'hF;
    b.last = last;
    return b;
  endfunction

endpackage

// File: rtl/aurora_rr_pick.sv
// Rotating-priority picker: first requester strictly after last_grant, with wrap.
module aurora_rr_pick
  import aurora_pkg::*;
#(
  parameter int unsigned ETHCOUNT = 4
) (
  input  logic [ETHCOUNT-1:0] req,
  input  logic [CH_W-1:0]     last_grant,
  output logic                found,
  output logic [CH_W-1:0]     idx
);

  logic [7:0] req_ext;
  logic [4:0] cand;

  always_comb begin
    req_ext = 8'(req);
    cand    = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned k = 1; k <= ETHCOUNT; k++) begin
      cand = 5'(last_grant) + 5'(k);
      if (cand >= 5'(ETHCOUNT)) cand = cand - 5'(ETHCOUNT);
      if (!found && req_ext[CH_W'(cand)]) begin
        found = 1'b1;
        idx   = CH_W'(cand);
      end
    end
  end

endmodule

// File: rtl/aurora_tx_arb.sv
// Packet-granular round-robin mux of ETHCOUNT AXIS sources onto the Aurora TX
// stream; each packet is prefixed with a channel header, stalled packets are aborted.
module aurora_tx_arb
  import aurora_pkg::*;
#(
  parameter int unsigned ETHCOUNT = 4,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [ETHCOUNT-1:0]        eth_mask,
  output logic [ETHCOUNT-1:0]        axis_s_tready,
  input  logic [ETHCOUNT*DATA_W-1:0] axis_s_tdata,
  input  logic [ETHCOUNT*KEEP_W-1:0] axis_s_tkeep,
  input  logic [ETHCOUNT-1:0]        axis_s_tvalid,
  input  logic [ETHCOUNT-1:0]        axis_s_tlast,
  input  logic                       axis_m_tready,
  output logic [DATA_W-1:0]          axis_m_tdata,
  output logic [KEEP_W-1:0]          axis_m_tkeep,
  output logic                       axis_m_tvalid,
  output logic                       axis_m_tlast,
  output logic [CH_W-1:0]            grant_idx,
  output logic                       busy,
  output logic                       err_timeout
);

  localparam int unsigned     CNT_W     = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(TIMEOUT - 1);
  localparam logic [7:0]       CH_COUNT  = 8'(ETHCOUNT);
  localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(ETHCOUNT - 1);

  state_t              state;
  beat_t               m_q;
  logic [CH_W-1:0]     last_grant;
  logic [CNT_W-1:0]    stall_cnt;
  logic                load_en;
  logic [ETHCOUNT-1:0] req;
  logic                found;
  logic [CH_W-1:0]     pick_idx;
  logic [7:0]          rdy_ext;
  logic [7:0]          ch_valid;
  logic [7:0]          ch_last;
  logic [DATA_W-1:0]   ch_data [8];
  logic [KEEP_W-1:0]   ch_keep [8];

  // Per-channel views padded to the 8-channel index space of grant_idx.
  assign ch_valid = 8'(axis_s_tvalid);
  assign ch_last  = 8'(axis_s_tlast);
  for (genvar g = 0; g < 8; g++) begin : g_ch
    if (g < ETHCOUNT) begin : g_on
      assign ch_data[g] = axis_s_tdata[g*DATA_W +: DATA_W];
      assign ch_keep[g] = axis_s_tkeep[g*KEEP_W +: KEEP_W];
    end else begin : g_off
      assign ch_data[g] = '0;
      assign ch_keep[g] = '0;
    end
  end

  assign load_en = !axis_m_tvalid || axis_m_tready;
  assign req     = axis_s_tvalid & ~eth_mask;

  aurora_rr_pick #(.ETHCOUNT(ETHCOUNT)) u_pick (
    .req        (req),
    .last_grant (last_grant),
    .found      (found),
    .idx        (pick_idx)
  );

  // Only the granted source sees ready, and only when the output slot can load.
  always_comb begin
    rdy_ext = '0;
    if (state == ST_DATA && load_en) rdy_ext = 8'd1 << grant_idx;
    axis_s_tready = ETHCOUNT'(rdy_ext);
  end

  assign axis_m_tdata = m_q.data;
  assign axis_m_tkeep = m_q.keep;
  assign axis_m_tlast = m_q.last;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= ST_IDLE;
      m_q           <= '0;
      axis_m_tvalid <= 1'b0;
      last_grant    <= LAST_CH;
      stall_cnt     <= '0;
      grant_idx     <= '0;
      busy          <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      err_timeout <= 1'b0;
      if (load_en) axis_m_tvalid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (found) begin
            grant_idx <= pick_idx;
            stall_cnt <= '0;
            busy      <= 1'b1;
            state     <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (load_en) begin
            m_q           <= tag_word(HDR_MAGIC, CH_COUNT, grant_idx, 1'b0);
            axis_m_tvalid <= 1'b1;
            state         <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (load_en) begin
            if (ch_valid[grant_idx]) begin
              m_q           <= '{data: ch_data[grant_idx], keep: ch_keep[grant_idx],
                                 last: ch_last[grant_idx]};
              axis_m_tvalid <= 1'b1;
              stall_cnt     <= '0;
              if (ch_last[grant_idx]) begin
                last_grant <= grant_idx;
                busy       <= 1'b0;
                state      <= ST_IDLE;
              end
            end else if (stall_cnt == STALL_MAX) begin
              // Source went quiet too long: close the packet with an abort word.
              m_q           <= tag_word(ABORT_MAGIC, 8'h00, grant_idx, 1'b1);
              axis_m_tvalid <= 1'b1;
              err_timeout   <= 1'b1;
              last_grant    <= grant_idx;
              stall_cnt     <= '0;
              busy          <= 1'b0;
              state         <= ST_IDLE;
            end else begin
              stall_cnt <= stall_cnt + 1'b1;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aurora_tx_arb.sv
// Directed bench for aurora_tx_arb: queued packet sources, an m-side capture
// monitor and per-scenario tasks comparing against hand-built expected streams.
module tb_aurora_tx_arb;

  localparam int unsigned N   = 4;
  localparam int unsigned TMO = 8;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [N-1:0]    eth_mask = '0;
  logic [N-1:0]    axis_s_tready;
  logic [N*32-1:0] axis_s_tdata = '0;
  logic [N*4-1:0]  axis_s_tkeep = '0;
  logic [N-1:0]    axis_s_tvalid = '0;
  logic [N-1:0]    axis_s_tlast = '0;
  logic            axis_m_tready = 1'b1;
  logic [31:0]     axis_m_tdata;
  logic [3:0]      axis_m_tkeep;
  logic            axis_m_tvalid;
  logic            axis_m_tlast;
  logic [2:0]      grant_idx;
  logic            busy;
  logic            err_timeout;

  aurora_tx_arb #(.ETHCOUNT(N), .TIMEOUT(TMO)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .eth_mask      (eth_mask),
    .axis_s_tready (axis_s_tready),
    .axis_s_tdata  (axis_s_tdata),
    .axis_s_tkeep  (axis_s_tkeep),
    .axis_s_tvalid (axis_s_tvalid),
    .axis_s_tlast  (axis_s_tlast),
    .axis_m_tready (axis_m_tready),
    .axis_m_tdata  (axis_m_tdata),
    .axis_m_tkeep  (axis_m_tkeep),
    .axis_m_tvalid (axis_m_tvalid),
    .axis_m_tlast  (axis_m_tlast),
    .grant_idx     (grant_idx),
    .busy          (busy),
    .err_timeout   (err_timeout)
  );

  always #5 clk = ~clk;

  // Beat encoding used everywhere in the bench: {last, keep, data}.
  logic [36:0] srcq [N][$];
  logic [36:0] cap [$];
  int          cap_cyc [$];
  logic [36:0] exp_q [$];
  logic [N-1:0] fire_s = '0;
  int fire_cnt [N] = '{default: 0};
  int rdy_cnt [N] = '{default: 0};
  int err_cycles = 0;
  int hold_err = 0;
  int stall_cyc = 0;
  int cyc = 0;
  logic        prev_stall = 1'b0;
  logic [36:0] held = '0;
  int n_pass = 0;
  int n_total = 0;

  function automatic logic [36:0] mk(input logic [31:0] d, input logic [3:0] k, input logic l);
    return {l, k, d};
  endfunction

  function automatic logic [31:0] wd(input int c, input int p, input int b);
    return {8'hC0, 8'(c), 8'(p), 8'(b)};
  endfunction

  function automatic logic [36:0] hdr(input int c);
    return mk({16'hA5C3, 8'h04, 8'(c)}, 4'hF, 1'b0);
  endfunction

  task automatic push_pkt(input int c, input int p, input int nb, input logic [3:0] lk);
    for (int b = 0; b < nb; b++)
      srcq[c].push_back(mk(wd(c, p, b), (b == nb - 1) ? lk : 4'hF, b == nb - 1));
  endtask

  task automatic add_exp(input int c, input int p, input int nb, input logic [3:0] lk);
    exp_q.push_back(hdr(c));
    for (int b = 0; b < nb; b++)
      exp_q.push_back(mk(wd(c, p, b), (b == nb - 1) ? lk : 4'hF, b == nb - 1));
  endtask

  // Index of the first difference between cap and exp_q, -1 when identical.
  function automatic int first_diff();
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= cap.size() || cap[i] !== exp_q[i]) return i;
    if (cap.size() != exp_q.size()) return exp_q.size();
    return -1;
  endfunction

  function automatic logic [36:0] at_q(input int i, input logic [36:0] q [$]);
    if (i >= 0 && i < q.size()) return q[i];
    return 'x;
  endfunction

  // Monitor: handshakes are decided by values stable at the falling edge.
  always @(negedge clk) begin
    logic [36:0] cur;
    cur = {axis_m_tlast, axis_m_tkeep, axis_m_tdata};
    cyc++;
    fire_s = rstn ? (axis_s_tvalid & axis_s_tready) : '0;
    for (int c = 0; c < N; c++) begin
      if (fire_s[c]) fire_cnt[c]++;
      if (axis_s_tready[c] === 1'b1) rdy_cnt[c]++;
    end
    if (err_timeout === 1'b1) err_cycles++;
    if (prev_stall && (axis_m_tvalid !== 1'b1 || cur !== held)) hold_err++;
    prev_stall = (axis_m_tvalid === 1'b1) && !axis_m_tready;
    if (prev_stall) stall_cyc++;
    held = cur;
    if (axis_m_tvalid === 1'b1 && axis_m_tready) begin
      cap.push_back(cur);
      cap_cyc.push_back(cyc);
    end
  end

  // Source driver: retire accepted beats, then present each queue head.
  always begin
    logic [36:0] b;
    @(posedge clk);
    #2;
    for (int c = 0; c < N; c++) begin
      if (fire_s[c] && srcq[c].size() > 0) void'(srcq[c].pop_front());
      if (srcq[c].size() > 0) begin
        b = srcq[c][0];
        axis_s_tdata[c*32 +: 32] = b[31:0];
        axis_s_tkeep[c*4 +: 4]   = b[35:32];
        axis_s_tlast[c]          = b[36];
        axis_s_tvalid[c]         = 1'b1;
      end else begin
        axis_s_tdata[c*32 +: 32] = '0;
        axis_s_tkeep[c*4 +: 4]   = '0;
        axis_s_tlast[c]          = 1'b0;
        axis_s_tvalid[c]         = 1'b0;
      end
    end
  end

  task automatic clear_obs();
    cap.delete();
    cap_cyc.delete();
    exp_q.delete();
    for (int c = 0; c < N; c++) begin
      fire_cnt[c] = 0;
      rdy_cnt[c]  = 0;
    end
    err_cycles = 0;
    hold_err   = 0;
    stall_cyc  = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstn = 1'b0;
    for (int c = 0; c < N; c++) srcq[c].delete();
    eth_mask      = '0;
    axis_m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    clear_obs();
  endtask

  task automatic wait_caps(input string name, input int n, input int budget);
    int k = 0;
    while (cap.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    repeat (4) @(posedge clk);
    #1;
    n_total++;
    if (cap.size() < n) $display("FAIL %s_wait: got %0d beats, required %0d", name, cap.size(), n);
    else n_pass++;
  endtask

  task automatic test_reset();
    int d;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    n_total++;
    if ({axis_m_tvalid, axis_m_tlast, axis_m_tkeep, axis_m_tdata, busy, err_timeout, grant_idx} !== '0)
      $display("FAIL reset_outputs: got v=%b l=%b k=%h d=%h busy=%b err=%b g=%0d, required all 0",
               axis_m_tvalid, axis_m_tlast, axis_m_tkeep, axis_m_tdata, busy, err_timeout, grant_idx);
    else n_pass++;
    n_total++;
    if (axis_s_tready !== '0) $display("FAIL reset_tready: got %b, required 0000", axis_s_tready);
    else n_pass++;
    // All channels masked: a pending packet must not be granted.
    @(posedge clk); #1;
    rstn = 1'b1;
    clear_obs();
    eth_mask = 4'hF;
    push_pkt(0, 0, 1, 4'hF);
    repeat (6) @(posedge clk);
    #1;
    n_total++;
    if (busy !== 1'b0 || cap.size() != 0 || rdy_cnt[0] != 0)
      $display("FAIL all_masked_idle: got busy=%b beats=%0d ready_cycles=%0d, required 0/0/0",
               busy, cap.size(), rdy_cnt[0]);
    else n_pass++;
    eth_mask = '0;
    add_exp(0, 0, 1, 4'hF);
    wait_caps("unmask", 2, 20);
    d = first_diff();
    n_total++;
    if (d >= 0) $display("FAIL unmask_stream: beat %0d got %h required %h", d, at_q(d, cap), at_q(d, exp_q));
    else n_pass++;
  endtask

  task automatic test_single();
    int d;
    int x;
    do_reset();
    x = cyc;
    push_pkt(1, 0, 3, 4'h3);
    add_exp(1, 0, 3, 4'h3);
    wait_caps("single", 4, 30);
    d = first_diff();
    n_total++;
    if (d >= 0) $display("FAIL single_stream: beat %0d got %h required %h", d, at_q(d, cap), at_q(d, exp_q));
    else n_pass++;
    n_total++;
    if (cap_cyc.size() < 4 || cap_cyc[0] != x + 3)
      $display("FAIL single_hdr_latency: got cycle %0d, required %0d", (cap_cyc.size() > 0) ? cap_cyc[0] : -1, x + 3);
    else n_pass++;
    n_total++;
    if (cap_cyc.size() < 4 || cap_cyc[3] - cap_cyc[0] != 3)
      $display("FAIL single_throughput: got span %0d, required 3", (cap_cyc.size() >= 4) ? cap_cyc[3] - cap_cyc[0] : -1);
    else n_pass++;
    n_total++;
    if (rdy_cnt[1] != 3 || rdy_cnt[0] != 0) $display("FAIL single_tready: got ch1=%0d ch0=%0d cycles, required 3/0", rdy_cnt[1], rdy_cnt[0]);
    else n_pass++;
    n_total++;
    if (grant_idx !== 3'd1 || busy !== 1'b0) $display("FAIL single_grant: got grant=%0d busy=%b, required 1/0", grant_idx, busy);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    int d;
    do_reset();
    push_pkt(0, 0, 2, 4'hF);
    push_pkt(0, 1, 2, 4'hF);
    for (int c = 1; c < N; c++) push_pkt(c, 0, 2, 4'hF);
    for (int c = 0; c < N; c++) add_exp(c, 0, 2, 4'hF);
    add_exp(0, 1, 2, 4'hF);
    wait_caps("rr", 15, 80);
    d = first_diff();
    n_total++;
    if (d >= 0) $display("FAIL rr_stream: beat %0d got %h required %h", d, at_q(d, cap), at_q(d, exp_q));
    else n_pass++;
  endtask

  task automatic test_mask();
    int d;
    int k;
    do_reset();
    eth_mask = 4'b0101;
    push_pkt(0, 0, 2, 4'hF);
    push_pkt(2, 0, 2, 4'hF);
    for (int p = 0; p < 2; p++) begin
      push_pkt(1, p, 2, 4'hF);
      push_pkt(3, p, 2, 4'hF);
      add_exp(1, p, 2, 4'hF);
      add_exp(3, p, 2, 4'hF);
    end
    wait_caps("mask", 12, 80);
    d = first_diff();
    n_total++;
    if (d >= 0) $display("FAIL mask_stream: beat %0d got %h required %h", d, at_q(d, cap), at_q(d, exp_q));
    else n_pass++;
    // Masking ch1 while its packet is in flight must not cut that packet.
    clear_obs();
    push_pkt(1, 2, 3, 4'hF);
    push_pkt(3, 2, 2, 4'hF);
    add_exp(1, 2, 3, 4'hF);
    add_exp(3, 2, 2, 4'hF);
    k = 0;
    while (fire_cnt[1] < 1 && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
    eth_mask = 4'b0111;
    wait_caps("mask_mid", 7, 40);
    d = first_diff();
    n_total++;
    if (d >= 0) $display("FAIL mask_mid_stream: beat %0d got %h required %h", d, at_q(d, cap), at_q(d, exp_q));
    else n_pass++;
    n_total++;
    if (rdy_cnt[0] != 0 || rdy_cnt[2] != 0 || srcq[0].size() != 2 || srcq[2].size() != 2)
      $display("FAIL mask_excluded: got ready ch0=%0d ch2=%0d left ch0=%0d ch2=%0d, required 0/0/2/2",
               rdy_cnt[0], rdy_cnt[2], srcq[0].size(), srcq[2].size());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int d;
    logic [3:0] pat;
    pat = 4'b1001;
    do_reset();
    push_pkt(0, 0, 4, 4'hF);
    add_exp(0, 0, 4, 4'hF);
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      axis_m_tready = pat[i % 4];
    end
    axis_m_tready = 1'b1;
    wait_caps("bp", 5, 20);
    d = first_diff();
    n_total++;
    if (d >= 0) $display("FAIL bp_stream: beat %0d got %h required %h (beats %0d)", d, at_q(d, cap), at_q(d, exp_q), cap.size());
    else n_pass++;
    n_total++;
    if (hold_err != 0) $display("FAIL bp_hold: got %0d unstable stalled cycles, required 0", hold_err);
    else n_pass++;
    n_total++;
    if (stall_cyc < 2) $display("FAIL bp_stalled: got %0d stalled cycles, required >= 2", stall_cyc);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int d;
    do_reset();
    push_pkt(2, 0, 1, 4'hF);
    srcq[2][0][36] = 1'b0;
    exp_q.push_back(hdr(2));
    exp_q.push_back(mk(wd(2, 0, 0), 4'hF, 1'b0));
    exp_q.push_back(mk(32'hDEAD_0002, 4'hF, 1'b1));
    wait_caps("timeout", 3, 40);
    d = first_diff();
    n_total++;
    if (d >= 0) $display("FAIL timeout_stream: beat %0d got %h required %h", d, at_q(d, cap), at_q(d, exp_q));
    else n_pass++;
    n_total++;
    if (cap_cyc.size() < 3 || cap_cyc[2] - cap_cyc[1] != TMO)
      $display("FAIL timeout_delay: got %0d cycles, required %0d", (cap_cyc.size() >= 3) ? cap_cyc[2] - cap_cyc[1] : -1, TMO);
    else n_pass++;
    n_total++;
    if (err_cycles != 1) $display("FAIL timeout_pulse: got %0d cycles high, required 1", err_cycles);
    else n_pass++;
    // Arbitration resumes after the aborted channel: ch3 before ch0.
    clear_obs();
    push_pkt(0, 0, 1, 4'hF);
    push_pkt(3, 0, 1, 4'hF);
    add_exp(3, 0, 1, 4'hF);
    add_exp(0, 0, 1, 4'hF);
    wait_caps("after_abort", 4, 30);
    d = first_diff();
    n_total++;
    if (d >= 0) $display("FAIL after_abort_stream: beat %0d got %h required %h", d, at_q(d, cap), at_q(d, exp_q));
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int d;
    int k;
    do_reset();
    push_pkt(0, 0, 3, 4'hF);
    k = 0;
    while (fire_cnt[0] < 1 && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
    rstn = 1'b0;
    srcq[0].delete();
    @(posedge clk);
    @(negedge clk); #1;
    n_total++;
    if ({axis_m_tvalid, axis_m_tlast, axis_m_tkeep, axis_m_tdata, busy, err_timeout, grant_idx, axis_s_tready} !== '0)
      $display("FAIL reset_mid_outputs: got v=%b d=%h busy=%b g=%0d rdy=%b, required all 0",
               axis_m_tvalid, axis_m_tdata, busy, grant_idx, axis_s_tready);
    else n_pass++;
    @(posedge clk); #1;
    rstn = 1'b1;
    clear_obs();
    push_pkt(3, 1, 1, 4'hF);
    push_pkt(0, 1, 1, 4'hF);
    add_exp(0, 1, 1, 4'hF);
    add_exp(3, 1, 1, 4'hF);
    wait_caps("reset_mid", 4, 30);
    d = first_diff();
    n_total++;
    if (d >= 0) $display("FAIL reset_mid_stream: beat %0d got %h required %h", d, at_q(d, cap), at_q(d, exp_q));
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_mask();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

endmodule
